// File: rtl/mul_div_if.sv
// mul_div_if: request/response and HI/LO access bundle for the multiply/divide unit
interface mul_div_if;
  logic start;
  logic [1:0] op;
  logic [31:0] A;
  logic [31:0] B;
  logic hi_we;
  logic lo_we;
  logic [31:0] wdata;
  logic busy;
  logic done;
  logic div_zero;
  logic [31:0] Hi;
  logic [31:0] Lo;
  modport master (output start, op, A, B, hi_we, lo_we, wdata, input busy, done, div_zero, Hi, Lo);
  modport slave (input start, op, A, B, hi_we, lo_we, wdata, output busy, done, div_zero, Hi, Lo);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: 32-step shift-add multiplier / restoring divider owning HI/LO
module mul_div_unit (
  input logic clk,
  input logic reset,
  mul_div_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nx;
  logic is_div, neg_lo, neg_hi, dz, done_r, dz_r, accept, sgn, rem_ge;
  logic [4:0] cnt;
  logic [63:0] acc, mul_nx, div_nx, prod;
  logic [31:0] b_r, a_abs, b_abs, hi_r, lo_r, quo, rem, rem_sub;
  logic [32:0] add_sum, rem_sh;
  assign accept = state == IDLE && bus.start;
  assign sgn = ~bus.op[0];
  assign a_abs = sgn && bus.A[31] ? -bus.A : bus.A;
  assign b_abs = sgn && bus.B[31] ? -bus.B : bus.B;
  assign add_sum = {1'b0, acc[63:32]} + {1'b0, b_r};
  assign mul_nx = acc[0] ? {add_sum, acc[31:1]} : {1'b0, acc[63:1]};
  assign rem_sh = acc[63:31];
  assign rem_ge = rem_sh >= {1'b0, b_r};
  assign rem_sub = rem_sh[31:0] - b_r;
  assign div_nx = rem_ge ? {rem_sub, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
  assign prod = neg_lo ? -acc : acc;
  assign quo = neg_lo ? -acc[31:0] : acc[31:0];
  assign rem = neg_hi ? -acc[63:32] : acc[63:32];
  assign bus.busy = state != IDLE;
  assign bus.done = done_r;
  assign bus.div_zero = dz_r;
  assign bus.Hi = hi_r;
  assign bus.Lo = lo_r;
  // state register; reset aborts any operation in flight
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // divide by zero skips the iteration and goes straight to FIX
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE ? (bus.start ? (bus.op[1] && bus.B == 32'd0 ? FIX : CALC) : IDLE) :
               state == CALC ? (cnt == 5'd31 ? FIX : CALC) : IDLE;
  end
  // operand latch, iteration datapath, and HI/LO update
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      dz <= 1'b0;
      cnt <= '0;
      acc <= '0;
      b_r <= '0;
      hi_r <= '0;
      lo_r <= '0;
      done_r <= 1'b0;
      dz_r <= 1'b0;
    end else begin
      done_r <= state == FIX;
      if (accept) begin
        is_div <= bus.op[1];
        neg_lo <= sgn & (bus.A[31] ^ bus.B[31]);
        neg_hi <= sgn & bus.op[1] & bus.A[31];
        dz <= bus.op[1] && bus.B == 32'd0;
        cnt <= '0;
        acc <= {32'd0, bus.op[1] ? a_abs : b_abs};
        b_r <= bus.op[1] ? b_abs : a_abs;
        dz_r <= 1'b0;
      end else if (state == CALC) begin
        cnt <= cnt + 5'd1;
        acc <= is_div ? div_nx : mul_nx;
      end
      if (state == FIX) begin
        hi_r <= dz ? 32'd0 : is_div ? rem : prod[63:32];
        lo_r <= dz ? 32'd0 : is_div ? quo : prod[31:0];
        dz_r <= dz;
      end else if (state == IDLE && !bus.start) begin
        if (bus.hi_we) hi_r <= bus.wdata;
        if (bus.lo_we) lo_r <= bus.wdata;
      end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vector table plus handshake/reset sequences for mul_div_unit
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int lat, bc, t;
  mul_div_if bus();
  mul_div_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int lat;
    logic dz;
  } vec_t;
  vec_t v[12];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op = op;
    bus.A = a;
    bus.B = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = 2'($urandom);
    bus.A = $urandom;
    bus.B = $urandom;
  endtask
  task automatic wait_done(output int l, output int c);
    l = 0;
    c = 0;
    while (!bus.done && l < 100) begin
      if (bus.busy) c++;
      @(negedge clk);
      l++;
    end
  endtask
  initial begin
    v[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 1'b0};
    v[1]  = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 1'b0};
    v[2]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 1'b0};
    v[3]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0};
    v[4]  = '{2'd3, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 33, 1'b0};
    v[5]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b0};
    v[6]  = '{2'd2, 32'h00000005, 32'h00000000, 32'h00000000, 32'h00000000, 1, 1'b1};
    v[7]  = '{2'd1, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 33, 1'b0};
    v[8]  = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 1'b0};
    v[9]  = '{2'd0, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 33, 1'b0};
    v[10] = '{2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0};
    v[11] = '{2'd2, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14, 33, 1'b0};
    bus.start = 1'b0;
    bus.op = 2'd0;
    bus.A = '0;
    bus.B = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst dz", 32'(bus.div_zero), 32'd0);
    chk("rst hi", bus.Hi, 32'd0);
    chk("rst lo", bus.Lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      launch(v[i].op, v[i].a, v[i].b);
      chk($sformatf("v%0d dz_clr", i), 32'(bus.div_zero), 32'd0);
      wait_done(lat, bc);
      chk($sformatf("v%0d hi", i), bus.Hi, v[i].hi);
      chk($sformatf("v%0d lo", i), bus.Lo, v[i].lo);
      chk($sformatf("v%0d lat", i), 32'(lat), 32'(v[i].lat));
      chk($sformatf("v%0d busy_cycles", i), 32'(bc), 32'(v[i].lat));
      chk($sformatf("v%0d dz", i), 32'(bus.div_zero), 32'(v[i].dz));
    end
    @(negedge clk);
    chk("done one cycle", 32'(bus.done), 32'd0);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    chk("mthi idle", bus.Hi, 32'h1234);
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hABCD;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    chk("mthi+mtlo hi", bus.Hi, 32'hABCD);
    chk("mthi+mtlo lo", bus.Lo, 32'hABCD);
    launch(2'd0, 32'hFFFFFFFD, 32'd7);
    repeat (3) @(negedge clk);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    chk("mthi busy hi", bus.Hi, 32'hABCD);
    chk("mthi busy flag", 32'(bus.busy), 32'd1);
    bus.start = 1'b1;
    bus.op = 2'd3;
    bus.A = 32'd100;
    bus.B = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, bc);
    t = lat + 5;
    chk("mid start lat", 32'(t), 32'd33);
    chk("mid start hi", bus.Hi, 32'hFFFFFFFF);
    chk("mid start lo", bus.Lo, 32'hFFFFFFEB);
    @(negedge clk);
    bus.lo_we = 1'b1;
    bus.wdata = 32'hDEAD;
    launch(2'd1, 32'd3, 32'd5);
    bus.lo_we = 1'b0;
    chk("start+mtlo no write", bus.Lo, 32'hFFFFFFEB);
    wait_done(lat, bc);
    chk("start+mtlo lo", bus.Lo, 32'd15);
    chk("start+mtlo hi", bus.Hi, 32'd0);
    launch(2'd1, 32'd6, 32'd7);
    wait_done(lat, bc);
    chk("b2b lat", 32'(lat), 32'd33);
    chk("b2b lo", bus.Lo, 32'd42);
    @(negedge clk);
    launch(2'd0, 32'd7, 32'd9);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort done", 32'(bus.done), 32'd0);
    chk("abort hi", bus.Hi, 32'd0);
    chk("abort lo", bus.Lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    launch(2'd1, 32'd3, 32'd4);
    wait_done(lat, bc);
    chk("post rst lat", 32'(lat), 32'd33);
    chk("post rst lo", bus.Lo, 32'd12);
    chk("post rst hi", bus.Hi, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
